trace_buffer_arbiter: RTL and testbench

// - Shares the single-port trace buffer (640 x {height[7:0], side}) between the tracer (writer) and the renderer (reader).
// - Tracer pushes traces via valid/ready; write column auto-increments 0..NUM_COLS-1 and wraps; frame_done pulses after the last column.
// - Renderer requests a column via req/ack; data is returned with a fixed latency. Reads have priority over writes.
// - Sits between tracer, row renderer and trace_buffer. Buffer height/side are bidirectional and are split into wr/rd/drive at top level.

---
 rtl/trace_buffer_arbiter.sv | 137 +++++++++++++
 tb/tb_trace_buffer_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_buffer_arbiter.sv
// Arbitrates the single-port trace buffer between the tracer (writes) and the renderer (reads).
// Reads win every decision; writes stream one per cycle with an auto-wrapping column counter.
module trace_buffer_arbiter #(
    parameter int NUM_COLS   = 640,
    parameter int COL_W      = 10,
    parameter int TURNAROUND = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tr_valid,
    output logic             tr_ready,
    input  logic [7:0]       tr_height,
    input  logic             tr_side,
    output logic             frame_done,
    input  logic             rd_req,
    input  logic [COL_W-1:0] rd_column,
    output logic             rd_ack,
    output logic [7:0]       rd_height,
    output logic             rd_side,
    output logic             buf_cs,
    output logic             buf_we,
    output logic             buf_oe,
    output logic [COL_W-1:0] buf_column,
    output logic             buf_drive,
    output logic [7:0]       buf_height_wr,
    output logic             buf_side_wr,
    input  logic [7:0]       buf_height_rd,
    input  logic             buf_side_rd
);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);

    typedef enum logic [2:0] {IDLE, WRITE, TURN, RD_ADDR, RD_CAP} state_e;

    state_e           state_q, state_d;
    logic [COL_W-1:0] wr_col_q, wr_col_d;
    logic [7:0]       tr_height_q;
    logic             tr_side_q;
    logic             frame_done_q;
    logic             rd_ack_q;
    logic [7:0]       rd_height_q;
    logic             rd_side_q;
    logic             accept;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                // A request still high during its own ack cycle is the one being acknowledged.
                if (rd_req) begin
                    if (!rd_ack_q) state_d = RD_ADDR;
                end else if (tr_valid) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (rd_req)        state_d = (TURNAROUND != 0) ? TURN : RD_ADDR;
                else if (tr_valid) state_d = WRITE;
                else               state_d = IDLE;
            end
            TURN:    state_d = RD_ADDR;
            RD_ADDR: state_d = RD_CAP;
            RD_CAP:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        buf_cs        = 1'b0;
        buf_we        = 1'b0;
        buf_oe        = 1'b0;
        buf_column    = '0;
        buf_height_wr = '0;
        buf_side_wr   = 1'b0;
        case (state_q)
            WRITE: begin
                buf_cs        = 1'b1;
                buf_we        = 1'b1;
                buf_column    = wr_col_q;
                buf_height_wr = tr_height_q;
                buf_side_wr   = tr_side_q;
            end
            RD_ADDR, RD_CAP: begin
                buf_cs     = 1'b1;
                buf_oe     = 1'b1;
                buf_column = rd_column;
            end
            default: ;
        endcase
    end

    // The transfer is taken at the edge that enters WRITE.
    assign accept    = (state_d == WRITE);
    assign tr_ready  = reset_n & accept;
    assign buf_drive = buf_we;

    assign wr_col_d = (state_q != WRITE) ? wr_col_q :
                      (wr_col_q == LAST_COL) ? '0 : wr_col_q + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_col_q     <= '0;
            tr_height_q  <= '0;
            tr_side_q    <= 1'b0;
            frame_done_q <= 1'b0;
            rd_ack_q     <= 1'b0;
            rd_height_q  <= '0;
            rd_side_q    <= 1'b0;
        end else begin
            wr_col_q     <= wr_col_d;
            frame_done_q <= (state_q == WRITE) && (wr_col_q == LAST_COL);
            rd_ack_q     <= (state_q == RD_CAP);
            if (accept) begin
                tr_height_q <= tr_height;
                tr_side_q   <= tr_side;
            end
            if (state_q == RD_CAP) begin
                rd_height_q <= buf_height_rd;
                rd_side_q   <= buf_side_rd;
            end
        end
    end

    assign frame_done = frame_done_q;
    assign rd_ack     = rd_ack_q;
    assign rd_height  = rd_height_q;
    assign rd_side    = rd_side_q;

endmodule

// File: tb/tb_trace_buffer_arbiter.sv
// Bench for trace_buffer_arbiter: a registered-read buffer model plus write/read scoreboards.
module tb_trace_buffer_arbiter;

    localparam int NUM_COLS   = 640;
    localparam int COL_W      = 10;
    localparam int TURNAROUND = 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);

    logic             clk = 1'b0;
    logic             reset_n;
    logic             tr_valid, tr_ready;
    logic [7:0]       tr_height;
    logic             tr_side;
    logic             frame_done;
    logic             rd_req;
    logic [COL_W-1:0] rd_column;
    logic             rd_ack;
    logic [7:0]       rd_height;
    logic             rd_side;
    logic             buf_cs, buf_we, buf_oe, buf_drive;
    logic [COL_W-1:0] buf_column;
    logic [7:0]       buf_height_wr, buf_height_rd;
    logic             buf_side_wr, buf_side_rd;

    always #5 clk = ~clk;

    trace_buffer_arbiter #(.NUM_COLS(NUM_COLS), .COL_W(COL_W), .TURNAROUND(TURNAROUND)) dut (
        .clk(clk), .reset_n(reset_n),
        .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_height(tr_height), .tr_side(tr_side),
        .frame_done(frame_done),
        .rd_req(rd_req), .rd_column(rd_column), .rd_ack(rd_ack),
        .rd_height(rd_height), .rd_side(rd_side),
        .buf_cs(buf_cs), .buf_we(buf_we), .buf_oe(buf_oe), .buf_column(buf_column),
        .buf_drive(buf_drive), .buf_height_wr(buf_height_wr), .buf_side_wr(buf_side_wr),
        .buf_height_rd(buf_height_rd), .buf_side_rd(buf_side_rd)
    );

    // Single-port buffer with a registered read.
    logic [8:0] mem [0:1023] = '{default: '0};
    logic [8:0] mem_rd_q = '0;
    always @(posedge clk) begin
        if (buf_cs && buf_we) mem[buf_column] <= {buf_height_wr, buf_side_wr};
        if (buf_cs && buf_oe) mem_rd_q <= mem[buf_column];
    end
    assign buf_height_rd = mem_rd_q[8:1];
    assign buf_side_rd   = mem_rd_q[0];

    typedef struct packed {
        logic [COL_W-1:0] col;
        logic [8:0]       data;
    } wr_exp_t;

    wr_exp_t    wr_q [$];
    logic [8:0] rd_q [$];
    logic [8:0] shadow [0:1023] = '{default: '0};

    int errors = 0;
    int checks = 0;
    int xfer_cnt = 0, ack_cnt = 0, fd_cnt = 0, turn_cnt = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    // Per-cycle monitor: scoreboards, invariants and event counters.
    initial begin
        wr_exp_t          e;
        logic [8:0]       r;
        logic [COL_W-1:0] exp_col;
        logic             fd_exp, fd_next, prev_ack, prev_fd, prev_we;
        exp_col = '0; fd_exp = 1'b0; prev_ack = 1'b0; prev_fd = 1'b0; prev_we = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                wr_q.delete();
                rd_q.delete();
                exp_col = '0; fd_exp = 1'b0; prev_ack = 1'b0; prev_fd = 1'b0; prev_we = 1'b0;
            end else begin
                check("we_oe_excl", 32'(buf_we & buf_oe), 32'd0);
                check("drive_eq_we", 32'(buf_drive), 32'(buf_we));
                check("ack_pulse", 32'(prev_ack & rd_ack), 32'd0);
                check("fd_pulse", 32'(prev_fd & frame_done), 32'd0);
                check("frame_done", 32'(frame_done), 32'(fd_exp));
                fd_next = 1'b0;
                if (buf_we) begin
                    check("wr_pending", 32'(wr_q.size() != 0), 32'd1);
                    if (wr_q.size() != 0) begin
                        e = wr_q.pop_front();
                        check("wr_col", 32'(buf_column), 32'(e.col));
                        check("wr_data", 32'({buf_height_wr, buf_side_wr}), 32'(e.data));
                        fd_next = (e.col == LAST_COL);
                        $display("write col=%0d data=0x%03h", buf_column, {buf_height_wr, buf_side_wr});
                    end
                end
                fd_exp = fd_next;
                if (tr_valid && tr_ready) begin
                    wr_q.push_back('{col: exp_col, data: {tr_height, tr_side}});
                    shadow[exp_col] = {tr_height, tr_side};
                    exp_col = (exp_col == LAST_COL) ? '0 : exp_col + 1'b1;
                    xfer_cnt++;
                end
                if (rd_ack) begin
                    check("rd_pending", 32'(rd_q.size() != 0), 32'd1);
                    if (rd_q.size() != 0) begin
                        r = rd_q.pop_front();
                        check("rd_data", 32'({rd_height, rd_side}), 32'(r));
                        $display("read ack height=0x%02h side=%0d", rd_height, rd_side);
                    end
                    ack_cnt++;
                end
                if (frame_done) fd_cnt++;
                if (prev_we && !buf_cs && rd_req) turn_cnt++;
                prev_ack = rd_ack;
                prev_fd  = frame_done;
                prev_we  = buf_we;
            end
        end
    end

    task automatic do_write(input logic [7:0] h, input logic s);
        int n;
        tr_valid  = 1'b1;
        tr_height = h;
        tr_side   = s;
        n = 0;
        @(negedge clk);
        while (!tr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("tr_ready_timeout", 32'(tr_ready), 32'd1);
        @(posedge clk); #1;
        tr_valid = 1'b0;
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!rd_ack && n < 20);
        if (!rd_ack) check("ack_timeout", 32'(rd_ack), 32'd1);
    endtask

    task automatic do_read(input logic [COL_W-1:0] col, input int exp_lat);
        int n;
        rd_column = col;
        rd_req    = 1'b1;
        rd_q.push_back(shadow[col]);
        wait_ack(n);
        rd_req = 1'b0;
        check("rd_latency", 32'(n), 32'(exp_lat));
    endtask

    initial begin
        int n, x0, f0, t0, a0;
        reset_n   = 1'b0;
        tr_valid  = 1'b1;
        rd_req    = 1'b1;
        rd_column = 10'd3;
        tr_height = 8'h11;
        tr_side   = 1'b1;

        // Reset with both requesters active.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ctrl", 32'({tr_ready, frame_done, rd_ack, buf_cs, buf_we, buf_oe, buf_drive, buf_side_wr, rd_side}), 32'd0);
        check("rst_data", 32'({rd_height, buf_column, buf_height_wr}), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        rd_q.push_back(shadow[3]);
        @(posedge clk);
        @(negedge clk);
        check("first_action", 32'({buf_cs, buf_we, buf_oe}), 32'b101);
        check("first_no_ready", 32'(tr_ready), 32'd0);
        tr_valid = 1'b0;
        wait_ack(n);
        rd_req = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Full frame of back-to-back writes.
        x0 = xfer_cnt;
        f0 = fd_cnt;
        for (int i = 0; i < NUM_COLS; i++) do_write(8'(i ^ 'h5A), 1'(i & 1));
        repeat (3) @(posedge clk); #1;
        check("stream_xfers", 32'(xfer_cnt - x0), 32'd640);
        check("frame_done_cnt", 32'(fd_cnt - f0), 32'd1);

        // Columns 0..5 of the next frame, column 5 = {A5,1}.
        for (int i = 0; i < 6; i++) do_write((i == 5) ? 8'hA5 : 8'(i + 1), (i == 5) ? 1'b1 : 1'b0);
        repeat (2) @(posedge clk); #1;
        do_read(10'd5, 3);
        check("rd5_height", 32'(rd_height), 32'hA5);
        check("rd5_side", 32'(rd_side), 32'd1);
        repeat (2) @(posedge clk); #1;
        do_read(10'd639, 3);
        repeat (1) @(posedge clk); #1;
        do_read(10'd100, 3);
        repeat (2) @(posedge clk); #1;

        // Read arriving inside a WRITE, then both sides held high continuously.
        tr_valid  = 1'b1;
        tr_height = 8'h77;
        tr_side   = 1'b0;
        n = 0;
        @(negedge clk);
        while (!tr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        t0 = turn_cnt;
        x0 = xfer_cnt;
        rd_column = 10'd600;
        rd_req    = 1'b1;
        rd_q.push_back(shadow[600]);
        wait_ack(n);
        check("wr_rd_latency", 32'(n), 32'(3 + TURNAROUND));
        for (int k = 0; k < 7; k++) begin
            rd_q.push_back(shadow[600]);
            wait_ack(n);
            check("rd_interval", 32'(n), 32'd4);
        end
        rd_req   = 1'b0;
        tr_valid = 1'b0;
        check("tracer_stall", 32'(xfer_cnt - x0), 32'd0);
        check("turn_seen", 32'(turn_cnt - t0), 32'(TURNAROUND));
        repeat (3) @(posedge clk); #1;

        // Reset dropped while the read sits in RD_CAP.
        rd_column = 10'd20;
        rd_req    = 1'b1;
        repeat (2) @(posedge clk); #1;
        check("in_rd_cap", 32'({buf_cs, buf_oe}), 32'b11);
        a0 = ack_cnt;
        reset_n = 1'b0;
        rd_req  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_no_ack", 32'(rd_ack), 32'd0);
        check("rst_rd_height", 32'(rd_height), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (3) @(posedge clk); #1;
        check("no_ack_after_rst", 32'(ack_cnt - a0), 32'd0);
        do_write(8'h3C, 1'b0);
        @(negedge clk);
        check("post_rst_we", 32'(buf_we), 32'd1);
        check("post_rst_col", 32'(buf_column), 32'd0);
        repeat (3) @(posedge clk); #1;

        check("wr_q_empty", 32'(wr_q.size()), 32'd0);
        check("rd_q_empty", 32'(rd_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
